// File: rtl/pipeline_feeder.sv
// ADC-to-DSP feeder: FIFO-buffers samples, issues one per pipeline round-trip, returns results to the DAC.
// Issue-to-dac_valid >= 3 cycles; a full FIFO drops new samples (overrun). `PIPELINE_FEEDER_LATENCY_EN adds latency ports.
module pipeline_feeder #(
  parameter int data_width     = 16,
  parameter int fifo_depth     = 4,
  parameter int timeout_cycles = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [data_width-1:0]         adc_sample,
  input  logic                          adc_valid,
  output logic [data_width-1:0]         pipe_sample,
  output logic                          pipe_in_valid,
  input  logic                          pipe_ready,
  input  logic [data_width-1:0]         pipe_out_sample,
  output logic [data_width-1:0]         dac_sample,
  output logic                          dac_valid,
  output logic                          overrun,
  output logic                          timeout,
  output logic [15:0]                   drop_count,
  output logic [$clog2(fifo_depth):0]   fifo_level
`ifdef PIPELINE_FEEDER_LATENCY_EN
  ,
  output logic [15:0]                   last_latency,
  output logic [15:0]                   max_latency
`endif
);

  localparam int PW = $clog2(fifo_depth);
  localparam int TW = $clog2(timeout_cycles);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(fifo_depth);
  localparam logic [TW-1:0] TMO_LAST = TW'(timeout_cycles - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                state_q, state_d;
  logic [data_width-1:0] mem_q [fifo_depth];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic [data_width-1:0] pipe_sample_q, pipe_sample_d;
  logic [data_width-1:0] dac_sample_q, dac_sample_d;
  logic                  pipe_in_valid_q, pipe_in_valid_d;
  logic                  dac_valid_q, dac_valid_d;
  logic                  overrun_q, overrun_d, timeout_q, timeout_d;
  logic [15:0]           drop_count_q, drop_count_d;
  logic                  push, pop, complete;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign pop      = (state_q == IDLE) && (count_q != '0) && pipe_ready;
  assign push     = adc_valid && ((count_q != FULL_CNT) || pop);
  assign complete = (state_q == WAIT_DONE) && pipe_ready;

  always_comb begin
    state_d         = state_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q + (PW+1)'(push) - (PW+1)'(pop);
    tmo_cnt_d       = tmo_cnt_q;
    pipe_sample_d   = pipe_sample_q;
    dac_sample_d    = dac_sample_q;
    pipe_in_valid_d = 1'b0;
    dac_valid_d     = 1'b0;
    overrun_d       = overrun_q;
    timeout_d       = timeout_q;
    drop_count_d    = drop_count_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (adc_valid && !push) begin
      overrun_d = 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (pop) begin
          rd_ptr_d        = rd_ptr_q + 1'b1;
          pipe_sample_d   = mem_q[rd_ptr_q];
          pipe_in_valid_d = 1'b1;
          tmo_cnt_d       = '0;
          state_d         = WAIT_BUSY;
        end
      end
      WAIT_BUSY, WAIT_DONE: begin
        // Ready high during WAIT_BUSY is the pipeline not yet having seen the issue pulse.
        if (complete) begin
          dac_sample_d = pipe_out_sample;
          dac_valid_d  = 1'b1;
          state_d      = IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if ((state_q == WAIT_BUSY) && !pipe_ready) state_d = WAIT_DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= adc_sample;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      tmo_cnt_q       <= '0;
      pipe_sample_q   <= '0;
      dac_sample_q    <= '0;
      pipe_in_valid_q <= 1'b0;
      dac_valid_q     <= 1'b0;
      overrun_q       <= 1'b0;
      timeout_q       <= 1'b0;
      drop_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      tmo_cnt_q       <= tmo_cnt_d;
      pipe_sample_q   <= pipe_sample_d;
      dac_sample_q    <= dac_sample_d;
      pipe_in_valid_q <= pipe_in_valid_d;
      dac_valid_q     <= dac_valid_d;
      overrun_q       <= overrun_d;
      timeout_q       <= timeout_d;
      drop_count_q    <= drop_count_d;
    end
  end

  assign pipe_sample   = pipe_sample_q;
  assign pipe_in_valid = pipe_in_valid_q;
  assign dac_sample    = dac_sample_q;
  assign dac_valid     = dac_valid_q;
  assign overrun       = overrun_q;
  assign timeout       = timeout_q;
  assign drop_count    = drop_count_q;
  assign fifo_level    = count_q;

`ifdef PIPELINE_FEEDER_LATENCY_EN
  logic [15:0] last_latency_q, last_latency_d, max_latency_q, max_latency_d;
  logic [31:0] lat_full;

  // The pulse cycle counts as 0, so completion lands one cycle after the final count.
  always_comb begin
    lat_full       = 32'(tmo_cnt_q) + 32'd1;
    last_latency_d = last_latency_q;
    max_latency_d  = max_latency_q;
    if (complete) begin
      last_latency_d = (lat_full > 32'h0000_FFFF) ? 16'hFFFF : lat_full[15:0];
      if (last_latency_d > max_latency_q) max_latency_d = last_latency_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_latency_q <= '0;
      max_latency_q  <= '0;
    end else begin
      last_latency_q <= last_latency_d;
      max_latency_q  <= max_latency_d;
    end
  end

  assign last_latency = last_latency_q;
  assign max_latency  = max_latency_q;
`endif

endmodule

// File: tb/tb_pipeline_feeder.sv
// Directed bench for pipeline_feeder with a behavioural DSP pipeline model (fifo_depth=4, timeout_cycles=16).
module tb_pipeline_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] adc_sample = '0;
  logic        adc_valid = 1'b0;
  logic [15:0] pipe_sample;
  logic        pipe_in_valid;
  wire         pipe_ready;
  wire  [15:0] pipe_out_sample;
  logic [15:0] dac_sample;
  logic        dac_valid;
  logic        overrun;
  logic        timeout;
  logic [15:0] drop_count;
  logic [2:0]  fifo_level;
`ifdef PIPELINE_FEEDER_LATENCY_EN
  logic [15:0] last_latency;
  logic [15:0] max_latency;
`endif

  pipeline_feeder #(.data_width(16), .fifo_depth(4), .timeout_cycles(16)) dut (
    .clk(clk), .reset(reset), .adc_sample(adc_sample), .adc_valid(adc_valid),
    .pipe_sample(pipe_sample), .pipe_in_valid(pipe_in_valid), .pipe_ready(pipe_ready),
    .pipe_out_sample(pipe_out_sample), .dac_sample(dac_sample), .dac_valid(dac_valid),
    .overrun(overrun), .timeout(timeout), .drop_count(drop_count), .fifo_level(fifo_level)
`ifdef PIPELINE_FEEDER_LATENCY_EN
    , .last_latency(last_latency), .max_latency(max_latency)
`endif
  );

  always #5 clk = ~clk;

  // Pipeline model: ready drops the cycle after in_valid, stays low for `delay` cycles.
  int          delay = 5;
  logic        op_neg = 1'b0;
  logic [15:0] const_val = 16'h0ABC;
  logic        hang = 1'b0;
  logic        stall = 1'b0;
  logic        model_rdy = 1'b1;
  logic [15:0] model_out = '0;
  logic        got = 1'b0;
  logic        busy = 1'b0;
  int          remain = 0;
  logic [15:0] cap = '0;

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      model_rdy = 1'b1;
      got = 1'b0;
      busy = 1'b0;
      remain = 0;
    end else begin
      if (busy) begin
        if (!hang) begin
          remain = remain - 1;
          if (remain <= 0) begin
            model_rdy = 1'b1;
            model_out = op_neg ? -cap : const_val;
            busy = 1'b0;
          end
        end
      end else if (got) begin
        model_rdy = 1'b0;
        busy = 1'b1;
        remain = delay;
        got = 1'b0;
      end
      if (pipe_in_valid) begin
        got = 1'b1;
        cap = pipe_sample;
      end
    end
  end

  assign pipe_ready      = model_rdy & ~stall;
  assign pipe_out_sample = model_out;

  int          cyc = 0;
  int          issue_cnt = 0;
  int          dac_cnt = 0;
  int          viol = 0;
  int          issue_cyc = 0;
  int          dac_cyc = 0;
  logic        outstanding = 1'b0;
  logic [15:0] last_issue = '0;
  logic [15:0] dac_log[$];

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      outstanding = 1'b0;
    end else begin
      if (dac_valid) begin
        dac_cnt++;
        dac_log.push_back(dac_sample);
        dac_cyc = cyc;
        outstanding = 1'b0;
      end
      if (pipe_in_valid) begin
        if (outstanding) viol++;
        outstanding = 1'b1;
        issue_cnt++;
        last_issue = pipe_sample;
        issue_cyc = cyc;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] v);
    adc_sample = v;
    adc_valid  = 1'b1;
    tick(1);
    adc_valid  = 1'b0;
  endtask

  int ib, db;

  initial begin
    tick(3);
    check_val("rst_pipe_in_valid", 32'(pipe_in_valid), 32'd0);
    check_val("rst_dac_valid", 32'(dac_valid), 32'd0);
    check_val("rst_pipe_sample", 32'(pipe_sample), 32'd0);
    check_val("rst_dac_sample", 32'(dac_sample), 32'd0);
    check_val("rst_overrun", 32'(overrun), 32'd0);
    check_val("rst_timeout", 32'(timeout), 32'd0);
    check_val("rst_drop_count", 32'(drop_count), 32'd0);
    check_val("rst_fifo_level", 32'(fifo_level), 32'd0);
    reset = 1'b1;
    tick(2);

    // Single sample, delay 5: in_valid to dac_valid is 7 cycles.
    ib = issue_cnt; db = dac_log.size();
    push(16'h1234);
    tick(15);
    check_val("t1_issues", 32'(issue_cnt - ib), 32'd1);
    check_val("t1_issue_sample", 32'(last_issue), 32'h1234);
    check_val("t1_dacs", 32'(dac_log.size() - db), 32'd1);
    if (dac_log.size() > db) check_val("t1_dac_sample", 32'(dac_log[db]), 32'h0ABC);
    check_val("t1_latency", 32'(dac_cyc - issue_cyc), 32'd7);
    check_val("t1_fifo_level", 32'(fifo_level), 32'd0);
`ifdef PIPELINE_FEEDER_LATENCY_EN
    check_val("t1_last_latency", 32'(last_latency), 32'd7);
`endif

    // Ordering with minimum-latency pipeline, negating.
    op_neg = 1'b1; delay = 1;
    ib = viol; db = dac_log.size();
    push(16'd1); push(16'd2); push(16'd3);
    tick(30);
    check_val("ord_dacs", 32'(dac_log.size() - db), 32'd3);
    if (dac_log.size() >= db + 3) begin
      check_val("ord_0", 32'(dac_log[db]), 32'hFFFF);
      check_val("ord_1", 32'(dac_log[db+1]), 32'hFFFE);
      check_val("ord_2", 32'(dac_log[db+2]), 32'hFFFD);
    end
    check_val("ord_overlap", 32'(viol - ib), 32'd0);
    check_val("ord_min_latency", 32'(dac_cyc - issue_cyc), 32'd3);

    // Full boundary: pop and push in the same cycle.
    stall = 1'b1;
    db = dac_log.size();
    for (int i = 0; i < 4; i++) push(16'h20 + 16'(i));
    check_val("fb_fill_level", 32'(fifo_level), 32'd4);
    adc_sample = 16'h24; adc_valid = 1'b1; stall = 1'b0;
    tick(1);
    adc_valid = 1'b0;
    check_val("fb_level", 32'(fifo_level), 32'd4);
    check_val("fb_overrun", 32'(overrun), 32'd0);
    check_val("fb_drops", 32'(drop_count), 32'd0);
    tick(40);
    check_val("fb_dacs", 32'(dac_log.size() - db), 32'd5);
    if (dac_log.size() >= db + 5) begin
      check_val("fb_first", 32'(dac_log[db]), 32'hFFE0);
      check_val("fb_last", 32'(dac_log[db+4]), 32'hFFDC);
    end

    // Overrun: six pushes into a stalled four-deep FIFO.
    stall = 1'b1;
    db = dac_log.size();
    for (int i = 0; i < 6; i++) push(16'h10 + 16'(i));
    check_val("ovr_level", 32'(fifo_level), 32'd4);
    check_val("ovr_flag", 32'(overrun), 32'd1);
    check_val("ovr_drops", 32'(drop_count), 32'd2);
    stall = 1'b0;
    tick(40);
    check_val("ovr_dacs", 32'(dac_log.size() - db), 32'd4);
    if (dac_log.size() >= db + 4) begin
      check_val("ovr_0", 32'(dac_log[db]), 32'hFFF0);
      check_val("ovr_1", 32'(dac_log[db+1]), 32'hFFEF);
      check_val("ovr_2", 32'(dac_log[db+2]), 32'hFFEE);
      check_val("ovr_3", 32'(dac_log[db+3]), 32'hFFED);
    end

    // Timeout: the pipeline hangs on 0x30; 0x31 waits behind it.
    hang = 1'b1;
    ib = issue_cnt; db = dac_log.size();
    push(16'h30);
    push(16'h31);
    tick(15);
    check_val("tmo_early", 32'(timeout), 32'd0);
    tick(1);
    check_val("tmo_set", 32'(timeout), 32'd1);
    check_val("tmo_no_dac", 32'(dac_log.size() - db), 32'd0);
    check_val("tmo_queued", 32'(fifo_level), 32'd1);
    check_val("tmo_dac_hold", 32'(dac_sample), 32'hFFED);
    hang = 1'b0;
    tick(20);
    check_val("tmo_issues", 32'(issue_cnt - ib), 32'd2);
    check_val("tmo_dacs", 32'(dac_log.size() - db), 32'd1);
    if (dac_log.size() > db) check_val("tmo_next", 32'(dac_log[db]), 32'hFFCF);

    // Asynchronous reset during WAIT_DONE with two samples queued.
    delay = 8;
    push(16'h40); push(16'h41); push(16'h42);
    tick(2);
    check_val("ar_pre_level", 32'(fifo_level), 32'd2);
    ib = issue_cnt; db = dac_log.size();
    #2 reset = 1'b0;
    #1;
    check_val("ar_level", 32'(fifo_level), 32'd0);
    check_val("ar_pipe_sample", 32'(pipe_sample), 32'd0);
    check_val("ar_dac_sample", 32'(dac_sample), 32'd0);
    check_val("ar_overrun", 32'(overrun), 32'd0);
    check_val("ar_timeout", 32'(timeout), 32'd0);
    check_val("ar_drops", 32'(drop_count), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(20);
    check_val("ar_no_dac", 32'(dac_log.size() - db), 32'd0);
    check_val("ar_no_issue", 32'(issue_cnt - ib), 32'd0);
    push(16'h50);
    tick(30);
    check_val("ar_new_dacs", 32'(dac_log.size() - db), 32'd1);
    if (dac_log.size() > db) check_val("ar_new_sample", 32'(dac_log[db]), 32'hFFB0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
